// File: rtl/apb16_slave_mem_if.sv
// apb16_slave_mem_if -- 16-bit APB bus bundle between the downsizer's master
// side and the halfword memory slave.
//
// Signals:
//   PSEL, PENABLE, PWRITE, PADDR[7:0], PWDATA[15:0]  master -> slave
//   PRDATA[15:0], PREADY                             slave  -> master
//   PSLVERR                                          slave  -> master, only when
//                                                    APB16_SLAVE_PSLVERR_EN is defined
//
// Modports: master (drives request), slave (drives response).
interface apb16_slave_mem_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [15:0] PWDATA;
  logic [15:0] PRDATA;
  logic        PREADY;
`ifdef APB16_SLAVE_PSLVERR_EN
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
`else
  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
`endif
endinterface

// File: rtl/apb16_slave_mem.sv
// apb16_slave_mem -- APB slave backed by DEPTH 16-bit halfword registers,
// with WAIT_CYCLES wait states inserted in every access phase.
//
// Ports:
//   PCLK          clock, all state updates on its rising edge
//   PRESET        asynchronous active-high reset (clears FSM, latches, memory)
//   bus           apb16_slave_mem_if.slave (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//                 PRDATA/PREADY[/PSLVERR] out)
//   dbg_access_o  FSM state observation: 1 = ACCESS, 0 = IDLE
//
// Configuration macro: APB16_SLAVE_PSLVERR_EN adds the PSLVERR response,
// flagging out-of-range transfers in their PREADY cycle.
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0) seen in
// IDLE, which latches index/direction/data. The access phase then runs until
// an edge where PSEL=1, PENABLE=1 and PREADY=1; that edge commits a write and
// returns to IDLE. PREADY rises only after WAIT_CYCLES access cycles. Dropping
// PSEL during the access phase abandons the transfer without a memory update.
module apb16_slave_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb16_slave_mem_if.slave bus,
  output logic             dbg_access_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [6:0]  idx_q;
  logic        wr_q;
  logic [15:0] wdata_q;
  logic [15:0] mem_q [DEPTH];

  logic          ready;
  logic          in_range;
  logic [AW-1:0] mem_idx;
  logic          unused_addr0;

  // Byte lane select bit has no meaning for a halfword memory.
  assign unused_addr0 = bus.PADDR[0];

  assign ready    = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign in_range = ({1'b0, idx_q} < 8'(DEPTH));
  assign mem_idx  = idx_q[AW-1:0];

  assign bus.PREADY   = ready;
  assign dbg_access_o = (state_q == ACCESS);

  // Read data is only presented in the completing cycle of an in-range read,
  // so the bus sees zero at all other times.
  always_comb begin
    bus.PRDATA = 16'h0000;
    if (ready && !wr_q && in_range) begin
      bus.PRDATA = mem_q[mem_idx];
    end
  end

`ifdef APB16_SLAVE_PSLVERR_EN
  assign bus.PSLVERR = ready && !in_range;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 7'd0;
      wr_q    <= 1'b0;
      wdata_q <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            idx_q   <= bus.PADDR[7:1];
            wr_q    <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!bus.PSEL) begin
            state_q <= IDLE;
          end else if (bus.PENABLE && ready) begin
            // Out-of-range writes complete normally but touch nothing.
            if (wr_q && in_range) begin
              mem_q[mem_idx] <= wdata_q;
            end
            state_q <= IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
